// File: rtl/rv32_decode_queue_pkg.sv
// Shared RV32 decode types for the decode-stage queue: control word, entry layout,
// opcode constants and the small helpers the decoder builds on.
package rv32_decode_queue_pkg;

   localparam int CORE_RF_NUM_READ   = 2;
   localparam int DECQ_DEFAULT_DEPTH = 4;

   typedef logic [31:0] rv_instr_t;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } rv_alu_op_e;

   typedef struct packed {
      logic       invalid;
      logic       register_wb;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src_imm;
      logic       pc_src;
      rv_alu_op_e alu_op;
      logic [2:0] funct3;
   } rv_control_t;

   typedef struct packed {
      rv_control_t                 control;
      logic [CORE_RF_NUM_READ-1:0] use_rs;
      rv_instr_t                   instr;
      logic [31:0]                 pc;
      logic                        compressed;
   } decq_entry_t;

   // Control word of ADDI x0,x0,0: valid, no side effects.
   function automatic rv_control_t create_nop_ctrl();
      rv_control_t c;
      c             = '0;
      c.alu_src_imm = 1'b1;
      c.alu_op      = ALU_ADD;
      return c;
   endfunction

   function automatic rv_alu_op_e alu_op_from(input logic [2:0] funct3, input logic alt);
      rv_alu_op_e op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32_decq_fifo.sv
// Circular DEPTH-entry store for decoded entries. Push and pop arrive already
// qualified by the caller; flush clears pointers and occupancy but not storage.
module rv32_decq_fifo
   import rv32_decode_queue_pkg::*;
#(
   parameter int  DEPTH   = DECQ_DEFAULT_DEPTH,
   parameter type entry_t = decq_entry_t
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  entry_t                   wdata_i,
   output entry_t                   head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        mem_q [DEPTH];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // When full and popping, wr_ptr equals rd_ptr; the old head is read out
   // combinationally this cycle and overwritten at the edge.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/rv32_decode_queue.sv
// Decode-stage buffer: decodes fetched words on enqueue, queues them in order,
// and counts illegal instructions as they leave the queue.
module rv32_decode_queue
   import rv32_decode_queue_pkg::*;
#(
   parameter int DEPTH     = DECQ_DEFAULT_DEPTH,
   parameter int NUM_READ  = CORE_RF_NUM_READ,
   parameter int C_EXT_EN  = 0,
   parameter int ILL_CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  rv_instr_t                in_instr,
   input  logic [31:0]              in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output rv_control_t              out_control,
   output logic [NUM_READ-1:0]      out_use_rs,
   output rv_instr_t                out_instr,
   output logic [31:0]              out_pc,
   output logic                     out_compressed,
   output logic [$clog2(DEPTH):0]   count,
   output logic [ILL_CNT_W-1:0]     ill_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      rv_control_t         control;
      logic [NUM_READ-1:0] use_rs;
      rv_instr_t           instr;
      logic [31:0]         pc;
      logic                compressed;
   } entry_t;

   // Handshakes: a transfer happens on a cycle where valid && ready are both high;
   // flush suppresses transfers on both sides in the same cycle.
   logic                push, pop;
   logic [CW-1:0]       count_w;
   entry_t              in_entry, head;
   rv_control_t         dec_ctrl;
   logic [NUM_READ-1:0] dec_use_rs;
   logic                need_rs1, need_rs2, is_compressed, alt_op;
   logic [6:0]          opcode;
   logic [2:0]          funct3;
   logic [ILL_CNT_W-1:0] ill_q, ill_d;

   assign opcode        = in_instr[6:0];
   assign funct3        = in_instr[14:12];
   assign alt_op        = in_instr[30];
   assign is_compressed = (in_instr[1:0] != 2'b11);

   always_comb begin
      dec_ctrl             = create_nop_ctrl();
      dec_ctrl.alu_src_imm = 1'b0;
      dec_ctrl.funct3      = funct3;
      need_rs1             = 1'b0;
      need_rs2             = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec_ctrl.register_wb = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
         end
         OPC_AUIPC: begin
            dec_ctrl.register_wb = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_ctrl.pc_src      = 1'b1;
         end
         OPC_JAL: begin
            dec_ctrl.register_wb = 1'b1;
            dec_ctrl.jump        = 1'b1;
            dec_ctrl.pc_src      = 1'b1;
         end
         OPC_JALR: begin
            dec_ctrl.register_wb = 1'b1;
            dec_ctrl.jump        = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            need_rs1             = 1'b1;
         end
         OPC_BRANCH: begin
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = ALU_SUB;
            need_rs1        = 1'b1;
            need_rs2        = 1'b1;
         end
         OPC_LOAD: begin
            dec_ctrl.register_wb = 1'b1;
            dec_ctrl.mem_read    = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            need_rs1             = 1'b1;
         end
         OPC_STORE: begin
            dec_ctrl.mem_write   = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            need_rs1             = 1'b1;
            need_rs2             = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_ctrl.register_wb = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_ctrl.alu_op      = alu_op_from(funct3, alt_op && (funct3 == 3'b101));
            need_rs1             = 1'b1;
         end
         OPC_OP: begin
            dec_ctrl.register_wb = 1'b1;
            dec_ctrl.alu_op      = alu_op_from(funct3, alt_op);
            need_rs1             = 1'b1;
            need_rs2             = 1'b1;
         end
         OPC_MISC_MEM, OPC_SYSTEM: ;
         default: dec_ctrl.invalid = 1'b1;
      endcase
      if (in_instr[11:7] == 5'd0) dec_ctrl.register_wb = 1'b0;

      for (int i = 0; i < NUM_READ; i++) begin
         dec_use_rs[i] = (i == 0) ? need_rs1 : ((i == 1) ? need_rs2 : 1'b0);
      end

      // Compressed parcels are never expanded here: either parked as a NOP or killed.
      if (is_compressed) begin
         dec_use_rs = '0;
         if (C_EXT_EN != 0) dec_ctrl = create_nop_ctrl();
         else               dec_ctrl.invalid = 1'b1;
      end
   end

   assign in_entry.control    = dec_ctrl;
   assign in_entry.use_rs     = dec_use_rs;
   assign in_entry.instr      = in_instr;
   assign in_entry.pc         = in_pc;
   assign in_entry.compressed = is_compressed;

   assign out_valid = (count_w != '0);
   assign pop       = out_valid && out_ready && !flush;
   assign in_ready  = (count_w < CW'(DEPTH)) || pop;
   assign push      = in_valid && in_ready && !flush;

   rv32_decq_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .flush_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_entry),
      .head_o  (head),
      .count_o (count_w)
   );

   always_comb begin
      ill_d = ill_q;
      if (pop && head.control.invalid && (ill_q != '1)) ill_d = ill_q + ILL_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) ill_q <= '0;
      else         ill_q <= ill_d;
   end

   assign out_control    = head.control;
   assign out_use_rs     = head.use_rs;
   assign out_instr      = head.instr;
   assign out_pc         = head.pc;
   assign out_compressed = head.compressed;
   assign count          = count_w;
   assign ill_count      = ill_q;

endmodule

// File: tb/tb_rv32_decode_queue.sv
// Bench for rv32_decode_queue: a queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_rv32_decode_queue;
   import rv32_decode_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int NR    = 2;
   localparam int ILL_W = 2;
   localparam int CW    = 3;
   localparam int ILL_MAX = 3;

   localparam logic [31:0] W_ADDI = 32'h0050_0093;
   localparam logic [31:0] W_ADD  = 32'h0020_81B3;
   localparam logic [31:0] W_LW   = 32'h0000_A283;
   localparam logic [31:0] W_SW   = 32'h0020_A223;
   localparam logic [31:0] W_BEQ  = 32'h0020_8463;
   localparam logic [31:0] W_JAL  = 32'h0000_00EF;
   localparam logic [31:0] W_LUI  = 32'h1234_53B7;
   localparam logic [31:0] W_NOP  = 32'h0000_0013;
   localparam logic [31:0] W_ILL  = 32'h0000_007F;
   localparam logic [31:0] W_CLI  = 32'h0000_4501;

   logic              clk, resetn, flush, in_valid, in_ready, out_valid, out_ready, out_compressed;
   logic [31:0]       in_instr, in_pc, out_instr, out_pc;
   rv_control_t       out_control;
   logic [NR-1:0]     out_use_rs;
   logic [CW-1:0]     count;
   logic [ILL_W-1:0]  ill_count;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   int          ill_m    = 0;
   bit          model_ok = 0;
   logic [63:0] head_m;
   logic [7:0]  f_exp, f_act, f_mask;
   bit          pop_m, push_m;

   rv32_decode_queue #(
      .DEPTH     (DEPTH),
      .NUM_READ  (NR),
      .C_EXT_EN  (0),
      .ILL_CNT_W (ILL_W)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_instr       (in_instr),
      .in_pc          (in_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_control    (out_control),
      .out_use_rs     (out_use_rs),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_compressed (out_compressed),
      .count          (count),
      .ill_count      (ill_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural view of a word: {invalid, wb, mem_read, mem_write, branch, jump, rs1, rs2}
   function automatic logic [7:0] exp_fields(input logic [31:0] w);
      logic [7:0] f;
      if (w[1:0] != 2'b11) return 8'b1000_0000;
      case (w[6:0])
         7'h37, 7'h17: f = 8'b0100_0000;
         7'h6F:        f = 8'b0100_0100;
         7'h67:        f = 8'b0100_0110;
         7'h63:        f = 8'b0000_1011;
         7'h03:        f = 8'b0110_0010;
         7'h23:        f = 8'b0001_0011;
         7'h13:        f = 8'b0100_0010;
         7'h33:        f = 8'b0100_0011;
         7'h0F, 7'h73: f = 8'b0000_0000;
         default:      f = 8'b1000_0000;
      endcase
      if (w[11:7] == 5'd0) f[6] = 1'b0;
      return f;
   endfunction

   function automatic bit model_ready();
      return (exp_q.size() < DEPTH) || ((exp_q.size() > 0) && out_ready && !flush);
   endfunction

   // Compare against the model, then advance the model by what the next edge does.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("count", 64'(count), 64'(exp_q.size()));
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(model_ready()));
         chk("ill_count", 64'(ill_count), 64'(ill_m));
         if (exp_q.size() > 0) begin
            head_m = exp_q[0];
            chk("head_instr", 64'(out_instr), 64'(head_m[63:32]));
            chk("head_pc", 64'(out_pc), 64'(head_m[31:0]));
            chk("head_compressed", 64'(out_compressed), 64'(head_m[33:32] != 2'b11));
            f_exp  = exp_fields(head_m[63:32]);
            f_mask = (head_m[33:32] != 2'b11) ? 8'h83 : 8'hFF;
            f_act  = {out_control.invalid, out_control.register_wb, out_control.mem_read,
                      out_control.mem_write, out_control.branch, out_control.jump,
                      out_use_rs[0], out_use_rs[1]};
            chk("head_fields", 64'(f_act & f_mask), 64'(f_exp & f_mask));
         end
      end
      if (!resetn) begin
         exp_q.delete();
         ill_m    = 0;
         model_ok = 1;
      end else if (flush) begin
         exp_q.delete();
      end else begin
         pop_m  = (exp_q.size() > 0) && out_ready;
         push_m = in_valid && model_ready();
         if (pop_m) begin
            head_m = exp_q.pop_front();
            if (exp_fields(head_m[63:32])[7] && ill_m < ILL_MAX) ill_m++;
         end
         if (push_m) exp_q.push_back({in_instr, in_pc});
      end
   end

   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = w;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_cycles(input int n);
      resetn   = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      resetn = 1'b1;
   endtask

   int ill_seq [5] = '{1, 2, 3, 3, 3};
   int idx, guard;

   initial begin
      resetn    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;

      rst_cycles(2);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_ill", 64'(ill_count), 64'd0);

      // first beat latency and ADDI decode
      drive(1, W_ADDI, 32'h100, 0, 0);
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi_pc", 64'(out_pc), 64'h100);
      chk("addi_rs0", 64'(out_use_rs[0]), 64'd1);
      chk("addi_wb", 64'(out_control.register_wb), 64'd1);
      chk("addi_count", 64'(count), 64'd1);
      drive(0, 0, 0, 1, 0);
      chk("addi_drain", 64'(count), 64'd0);

      // fill to DEPTH, hold the fifth beat, then pop and push together
      drive(1, W_LW,  32'h200, 0, 0);
      drive(1, W_SW,  32'h204, 0, 0);
      drive(1, W_BEQ, 32'h208, 0, 0);
      drive(1, W_ADD, 32'h20C, 0, 0);
      chk("full_count", 64'(count), 64'd4);
      in_valid = 1'b1; in_instr = W_JAL; in_pc = 32'h210; out_ready = 1'b0;
      #1;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("held_count", 64'(count), 64'd4);
      chk("held_head", 64'(out_pc), 64'h200);
      drive(1, W_JAL, 32'h210, 1, 0);
      chk("pp_count", 64'(count), 64'd4);
      chk("pp_head", 64'(out_pc), 64'h204);
      repeat (4) drive(0, 0, 0, 1, 0);
      chk("full_drain", 64'(count), 64'd0);

      // flush drops queued entries and the concurrent beat
      drive(1, W_LUI, 32'h300, 0, 0);
      drive(1, W_ADD, 32'h304, 0, 0);
      drive(1, W_NOP, 32'h308, 0, 0);
      drive(1, W_LW,  32'h30C, 0, 1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      drive(0, 0, 0, 0, 0);
      chk("flush_beat_gone", 64'(out_valid), 64'd0);

      // compressed parcel with C disabled
      drive(1, W_CLI, 32'h400, 0, 0);
      chk("cli_compressed", 64'(out_compressed), 64'd1);
      chk("cli_invalid", 64'(out_control.invalid), 64'd1);
      chk("cli_use_rs", 64'(out_use_rs), 64'd0);
      drive(0, 0, 0, 1, 0);
      chk("cli_ill", 64'(ill_count), 64'd1);

      // illegal counter saturation at ILL_W=2
      rst_cycles(1);
      chk("sat_rst_ill", 64'(ill_count), 64'd0);
      for (int k = 0; k < 4; k++) drive(1, W_ILL, 32'h500 + 32'(4 * k), 0, 0);
      drive(1, W_ILL, 32'h510, 1, 0);
      chk("sat_ill_0", 64'(ill_count), 64'(ill_seq[0]));
      for (int k = 1; k < 5; k++) begin
         drive(0, 0, 0, 1, 0);
         chk($sformatf("sat_ill_%0d", k), 64'(ill_count), 64'(ill_seq[k]));
      end

      // eight sequential PCs with random consumer stalls, wrapping the pointers
      rst_cycles(1);
      idx   = 0;
      guard = 0;
      while (idx < 8 && guard < 200) begin
         in_valid  = 1'b1;
         in_instr  = 32'h0000_0093 | (32'(idx) << 20);
         in_pc     = 32'(idx * 4);
         out_ready = 1'($urandom_range(0, 1));
         flush     = 1'b0;
         if (model_ready()) idx++;
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid = 1'b0;
      while (exp_q.size() > 0 && guard < 200) begin
         drive(0, 0, 0, 1'($urandom_range(0, 1)), 0);
         guard++;
      end
      chk("seq_pushed", 64'(idx), 64'd8);
      chk("seq_count", 64'(count), 64'd0);

      // reset mid-burst empties the queue
      drive(1, W_ADD, 32'h600, 0, 0);
      drive(1, W_LW,  32'h604, 0, 0);
      drive(1, W_SW,  32'h608, 0, 0);
      resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      in_valid = 1'b0;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32_decode_queue.md
Name: rv32_decode_queue

Overview:
Parametrised decode-stage buffer. It accepts fetched instruction words with their PC over a valid/ready handshake and decodes each word on enqueue into rv_control_t plus per-read-port use_rs flags. Decoded entries are held in a DEPTH-entry circular FIFO and presented in order to the issue/hazard logic over a second valid/ready handshake. Additions over the current single-instruction combinational decoder:
- buffering with backpressure;
- pipeline flush;
- compressed-parcel detection with a C-disable mode;
- a saturating illegal-instruction counter.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2.
NUM_READ, CORE_RF_NUM_READ, number of use_rs flags per entry.
C_EXT_EN, 0, 1 means compressed encodings are tagged but left valid; 0 means they are forced invalid.
ILL_CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  in  1  core clock.
resetn  in  1  synchronous active-low reset.
flush  in  1  discard all queued entries.
in_valid  in  1  fetch beat valid.
in_ready  out  1  queue can accept this cycle.
in_instr  in  32  rv_instr_t word.
in_pc  in  32  PC of in_instr.
out_valid  out  1  head entry valid.
out_ready  in  1  consumer takes head.
out_control  out  rv_control_t  decoded control of head.
out_use_rs  out  NUM_READ  register-use flags of head (bit i = read port i).
out_instr  out  32  raw word of head.
out_pc  out  32  PC of head.
out_compressed  out  1  head bits[1:0] != 2'b11.
count  out  $clog2(DEPTH)+1  occupied entries.
ill_count  out  ILL_CNT_W  illegal instructions retired from the queue.

Behaviour:
- One clock: clk. Reset is synchronous and active-low: resetn sampled on rising clk.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, out_valid=0, ill_count=0. Entry storage is not reset.
- Push and pop conditions:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready && !flush.
- in_ready = (count < DEPTH) || pop. Full-and-popping accepts a new beat in the same cycle.
- out_valid = (count != 0). Head fields are driven combinationally from storage at rd_ptr.
- Latency: a word pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no same-cycle bypass.
- Decode on push, combinational, using core decode rules:
  - control per opcode/funct3/funct7; use_rs per operand usage; register_wb cleared when rd==0; unknown opcode sets control.invalid.
  - compressed = (instr[1:0] != 2'b11).
  - If compressed and C_EXT_EN==0, force control.invalid=1 and all use_rs=0.
  - If compressed and C_EXT_EN==1, store the NOP control (create_nop_ctrl) with compressed=1; expansion is out of scope.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count update: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
- Flush has priority over everything:
  - next cycle: count=0, rd_ptr=wr_ptr=0, out_valid=0.
  - A beat presented with flush is dropped.
  - The head is not considered consumed; ill_count is not incremented.
- ill_count increments on each pop whose head control.invalid==1 and saturates at all-ones (no wrap).
- Asserting resetn low mid-stream empties the queue on the next edge, regardless of in_valid, out_ready or flush.
- Ordering: strict FIFO. No entry is duplicated or lost except by flush or reset.

Decomposition:
- Add to rv32_types:
  - decq_entry_t = struct {rv_control_t control; logic [NUM_READ-1:0] use_rs; rv_instr_t instr; logic [31:0] pc; logic compressed}.
  - Constant DECQ_DEFAULT_DEPTH=4.
- Sub-module rv32_decq_fifo: generic DEPTH-entry circular storage of decq_entry_t with push/pop/flush, pointers and count.
- The top level holds the decode logic, the C-disable override and the illegal counter.

Test Plan:
- Reset then push ADDI x1,x0,5 (0x00500093) at PC 0x100 with out_ready=0 -> next cycle out_valid=1, out_pc=0x100, out_use_rs[0]=1, register_wb=1, count=1.
- DEPTH=4, out_ready=0, push 5 beats -> in_ready=0 after the 4th; the 5th is held; count=4. Then out_ready=1 for one cycle with in_valid=1 -> pop and push in the same cycle; count stays 4.
- Push 3 words, assert flush for one cycle together with in_valid=1 -> next cycle count=0, out_valid=0; the flush-cycle beat never appears.
- C_EXT_EN=0, push 0x4501 (c.li) -> out_compressed=1, control.invalid=1, use_rs all 0. On pop, ill_count increments from 0 to 1.
- ILL_CNT_W=2, pop 5 invalid words (opcode 0x7F) -> ill_count reads 1, 2, 3, 3, 3.
- Push 8 sequential PCs 0x0..0x1C with random out_ready -> all popped in order with correct pointer wrap; resetn low mid-burst -> queue empty next cycle.
